// File: rtl/uart2_rx_led_monitor.sv
// UART2 receive monitor: 2-flop synchronised RXD, 8-N-1 (or 8-E-1) deframing, byte strobe and LED latch.
// Define UART2_RX_PARITY_EN to build the even-parity (8-E-1) variant; default is 8-N-1.
module uart2_rx_led_monitor #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       BUSY,
  output logic [7:0] LED
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART2_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic [7:0]       r_led;
  logic             r_valid;
  logic             r_ferr;
  logic             r_rxd_meta;
  logic             r_rxd_sync;
  logic             w_par_bad;

`ifdef UART2_RX_PARITY_EN
  logic r_par_bad;
  logic r_perr;
  assign w_par_bad  = r_par_bad;
  assign PARITY_ERR = r_perr;
`else
  assign w_par_bad  = 1'b0;
  assign PARITY_ERR = 1'b0;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_led     <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART2_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART2_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!r_rxd_sync) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= r_rxd_sync ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {r_rxd_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART2_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART2_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_par_bad <= (r_rxd_sync != ^r_shift);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start edge.
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (!r_rxd_sync) begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end else if (w_par_bad) begin
`ifdef UART2_RX_PARITY_EN
              r_perr  <= 1'b1;
`endif
              r_state <= S_IDLE;
            end else begin
              r_data  <= r_shift;
              r_led   <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rxd_sync) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DATA      = r_data;
  assign LED       = r_led;
  assign VALID     = r_valid;
  assign FRAME_ERR = r_ferr;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart2_rx_led_monitor.sv
// Directed bench for uart2_rx_led_monitor at default 50 MHz / 115200 baud.
// Parity cases are included when UART2_RX_PARITY_EN is defined.
module tb_uart2_rx_led_monitor;

  localparam int CPB = 50000000 / 115200;
`ifdef UART2_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       RXD = 1'b1;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       PARITY_ERR;
  logic       BUSY;
  logic [7:0] LED;

  uart2_rx_led_monitor dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .RXD        (RXD),
    .DATA       (DATA),
    .VALID      (VALID),
    .FRAME_ERR  (FRAME_ERR),
    .PARITY_ERR (PARITY_ERR),
    .BUSY       (BUSY),
    .LED        (LED)
  );

  always #10 CLK = ~CLK;

  int         checks = 0;
  int         failures = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  longint     cyc = 0;
  logic [7:0] vdata[$];
  logic [7:0] vled[$];
  longint     vtime[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (VALID) begin
      valid_cnt = valid_cnt + 1;
      vdata.push_back(DATA);
      vled.push_back(LED);
      vtime.push_back(cyc);
    end
    if (FRAME_ERR) ferr_cnt = ferr_cnt + 1;
    if (PARITY_ERR) perr_cnt = perr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    ferr_cnt  = 0;
    perr_cnt  = 0;
    vdata.delete();
    vled.delete();
    vtime.delete();
  endtask

  // Called on a negedge; leaves RXD at the stop value so back-to-back calls have no gap.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_bits);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef UART2_RX_PARITY_EN
    RXD = par;
    repeat (CPB) @(negedge CLK);
`else
    if (par) RXD = 1'b1;
`endif
    RXD = stop;
    repeat (CPB * stop_bits) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] b;
    longint     gap;

    // Reset state
    RSTN = 1'b0;
    RXD  = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_data", DATA, 8'h00);
    check("rst_led", LED, 8'h00);
    check("rst_valid", VALID, 1'b0);
    check("rst_ferr", FRAME_ERR, 1'b0);
    check("rst_perr", PARITY_ERR, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    RSTN = 1'b1;
    repeat (10) @(negedge CLK);

    // Short low glitch: rejected at start-bit midpoint
    clear_mon();
    RXD = 1'b0;
    repeat (100) @(negedge CLK);
    RXD = 1'b1;
    repeat (300) @(negedge CLK);
    check("glitch_valid", valid_cnt, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_busy", BUSY, 1'b0);
    check("glitch_data", DATA, 8'h00);

    // Single good byte 0xA5
    clear_mon();
    send_frame(8'hA5, ^8'hA5, 1'b1, 1);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("a5_valid_cnt", valid_cnt, 1);
    check("a5_data_at_valid", vdata[0], 8'hA5);
    check("a5_led_at_valid", vled[0], 8'hA5);
    check("a5_busy", BUSY, 1'b0);
    check("a5_data_hold", DATA, 8'hA5);

    // Stop bit 0, line held low three bit times, then recovery frame 0x5A
    clear_mon();
    send_frame(8'h3C, ^8'h3C, 1'b0, 3);
    check("ferr_busy_held", BUSY, 1'b1);
    RXD = 1'b1;
    repeat (CPB) @(negedge CLK);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_valid", valid_cnt, 0);
    check("ferr_perr", perr_cnt, 0);
    check("ferr_data", DATA, 8'hA5);
    check("ferr_led", LED, 8'hA5);
    check("ferr_busy_idle", BUSY, 1'b0);
    clear_mon();
    send_frame(8'h5A, ^8'h5A, 1'b1, 1);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("recover_valid", valid_cnt, 1);
    check("recover_data", DATA, 8'h5A);
    check("recover_ferr", ferr_cnt, 0);

    // Back-to-back 0x00 then 0xFF with a single stop bit
    clear_mon();
    send_frame(8'h00, ^8'h00, 1'b1, 1);
    send_frame(8'hFF, ^8'hFF, 1'b1, 1);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("b2b_valid_cnt", valid_cnt, 2);
    check("b2b_data0", vdata[0], 8'h00);
    check("b2b_data1", vdata[1], 8'hFF);
    gap = vtime[1] - vtime[0];
    check("b2b_gap_in_window", (gap >= FRAME_BITS * CPB - 2) && (gap <= FRAME_BITS * CPB + 2), 1'b1);

    // Reset during data bit 4 of 0x81
    clear_mon();
    b = 8'h81;
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = b[4];
    repeat (200) @(negedge CLK);
    check("mid_busy_before", BUSY, 1'b1);
    RSTN = 1'b0;
    #2;
    check("mid_rst_data", DATA, 8'h00);
    check("mid_rst_led", LED, 8'h00);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_valid", VALID, 1'b0);
    check("mid_rst_ferr", FRAME_ERR, 1'b0);
    @(negedge CLK);
    RXD = 1'b1;
    repeat (10) @(negedge CLK);
    RSTN = 1'b1;
    repeat (CPB * 2) @(negedge CLK);
    check("mid_no_strobe", valid_cnt + ferr_cnt + perr_cnt, 0);
    send_frame(8'h81, ^8'h81, 1'b1, 1);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("post_rst_valid", valid_cnt, 1);
    check("post_rst_data", DATA, 8'h81);
    check("post_rst_led", LED, 8'h81);

`ifdef UART2_RX_PARITY_EN
    // 0x07 has three ones, so even parity requires parity bit 1
    clear_mon();
    send_frame(8'h07, 1'b0, 1'b1, 1);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("par_bad_perr", perr_cnt, 1);
    check("par_bad_valid", valid_cnt, 0);
    check("par_bad_led", LED, 8'h81);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 1);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("par_ok_valid", valid_cnt, 1);
    check("par_ok_perr", perr_cnt, 0);
    check("par_ok_data", DATA, 8'h07);
`else
    check("noparity_perr_tied", perr_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
